// File: rtl/rf_pkg.sv
// Shared definitions for the integer register file with busy scoreboard:
// default sizes, the sweep/run state type and the hardwired-zero index.
package rf_pkg;

    localparam int XLEN_DEF  = 64;
    localparam int NREGS_DEF = 32;
    localparam int ZERO_REG  = 0;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_state_e;

endpackage

// File: rtl/rf_scoreboard_bits.sv
// Per-register busy flags: clear on writeback, set on issue (set wins),
// x0 never busy, with one combinational lookup per read port.
module rf_scoreboard_bits
    import rf_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_en,
    input  logic [AW-1:0]     clr_addr,
    input  logic              set_en,
    input  logic [AW-1:0]     set_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Set is applied after clear so a newer producer keeps the register pending.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_en) begin
            busy_d[set_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_lookup
            assign rd_busy[gi] = busy_q[rd_addr[gi*AW +: AW]];
        end
    endgenerate

endmodule

// File: rtl/rf_scoreboard.sv
// Parametrised register file: post-reset zeroing sweep, clocked writes,
// hardwired x0, NRD combinational read ports and a busy scoreboard.
// Optional same-cycle write forwarding is enabled by defining RF_BYPASS_EN.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic                ready
);

    logic [XLEN-1:0] mem_q [NREGS];
    rf_state_e       state_q, state_d;
    logic [AW-1:0]   sweep_idx_q, sweep_idx_d;
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [XLEN-1:0] mem_wdata;
    logic            run;
    logic [NRD-1:0]  sb_busy;

    assign run   = (state_q == RUN);
    assign ready = run;

    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        mem_we      = 1'b0;
        mem_waddr   = wr_addr;
        mem_wdata   = wr_data;
        case (state_q)
            INIT: begin
                mem_we      = 1'b1;
                mem_waddr   = sweep_idx_q;
                mem_wdata   = '0;
                sweep_idx_d = sweep_idx_q + 1'b1;
                if (sweep_idx_q == AW'(NREGS - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                mem_we = wr_en && (wr_addr != AW'(ZERO_REG));
            end
            default: state_d = INIT;
        endcase
        // The sweep restarts after reset anyway, so storage is left alone on that edge.
        if (rst) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT;
            sweep_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    rf_scoreboard_bits #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .AW    (AW)
    ) u_bits (
        .clk      (clk),
        .rst      (rst),
        .clr_en   (run && wr_en),
        .clr_addr (wr_addr),
        .set_en   (run && iss_en),
        .set_addr (iss_addr),
        .rd_addr  (rd_addr),
        .rd_busy  (sb_busy)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0]   addr;
            logic [XLEN-1:0] data;
            logic            busy;

            assign addr = rd_addr[gi*AW +: AW];

            always_comb begin
                data = '0;
                busy = 1'b0;
                if (run && (addr != AW'(ZERO_REG))) begin
                    data = mem_q[addr];
                    busy = sb_busy[gi];
`ifdef RF_BYPASS_EN
                    if (wr_en && (wr_addr == addr)) begin
                        data = wr_data;
                        busy = iss_en && (iss_addr == addr);
                    end
`endif
                end
            end

            assign rd_data[gi*XLEN +: XLEN] = data;
            assign rd_busy[gi]              = busy;
        end

        // Only reachable when NREGS is not a power of two.
        if ((1 << AW) != NREGS) begin : g_range_chk
            always_ff @(posedge clk) begin
                if (!rst && run) begin
                    if (wr_en) begin
                        assert (int'(wr_addr) < NREGS);
                    end
                    if (iss_en) begin
                        assert (int'(iss_addr) < NREGS);
                    end
                    for (int i = 0; i < NRD; i++) begin
                        assert (int'(rd_addr[i*AW +: AW]) < NREGS);
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed bench for rf_scoreboard (default 32x64, two read ports); expectations
// adapt to RF_BYPASS_EN when it is defined.
module tb_rf_scoreboard;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NRD*AW-1:0]   rd_addr = '0;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr_en = 1'b0;
    logic [AW-1:0]       wr_addr = '0;
    logic [XLEN-1:0]     wr_data = '0;
    logic                iss_en = 1'b0;
    logic [AW-1:0]       iss_addr = '0;
    logic                ready;

    int n_checks = 0;
    int n_errors = 0;
    int cycles;

    localparam logic [63:0] PAT5 = 64'h0123_4567_89AB_CDEF;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    rf_scoreboard #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRD   (NRD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .ready    (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    function automatic logic [63:0] data0();
        return rd_data[XLEN-1:0];
    endfunction

    function automatic logic [63:0] data1();
        return rd_data[2*XLEN-1:XLEN];
    endfunction

    // Counts edges until ready; optionally probes reads and pokes ignored
    // write/issue traffic at a chosen point in the sweep.
    task automatic wait_ready(output int n, input int probe_at, input int poke_at);
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            if (n == probe_at) begin
                check("sweep_rd0", data0(), 64'd0);
                check("sweep_rd1", data1(), 64'd0);
                check("sweep_busy", {62'd0, rd_busy}, 64'd0);
            end
            if (n == poke_at) begin
                wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'hFF;
                iss_en = 1'b1; iss_addr = 5'd3;
            end else begin
                wr_en = 1'b0; iss_en = 1'b0;
            end
            tick();
            n++;
        end
        wr_en = 1'b0; iss_en = 1'b0;
        settle();
    endtask

    initial begin
        // Power-up reset
        tick();
        check("rst_ready", {63'd0, ready}, 64'd0);
        check("rst_busy", {62'd0, rd_busy}, 64'd0);
        rst = 1'b0;
        settle();
        wait_ready(cycles, -1, -1);
        check("init_sweep_len", 64'(cycles), 64'd32);

        // Preload x3=47, x1=56
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'd47;
        tick();
        wr_addr = 5'd1; wr_data = 64'd56;
        tick();
        wr_en = 1'b0;
        set_rd(5'd1, 5'd3);
        settle();
        check("preload_r1", data0(), 64'd56);
        check("preload_r3", data1(), 64'd47);

        // Reset pulse clears everything via the sweep
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check("rst2_ready", {63'd0, ready}, 64'd0);
        wait_ready(cycles, 5, -1);
        check("sweep_len", 64'(cycles), 64'd32);
        check("post_r1", data0(), 64'd0);
        check("post_r3", data1(), 64'd0);

        // Write/read x5 in the same cycle
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = PAT5;
        set_rd(5'd5, 5'd0);
        settle();
        check("x5_same_cycle", data0(), BYP ? PAT5 : 64'd0);
        tick();
        wr_en = 1'b0;
        settle();
        check("x5_next_cycle", data0(), PAT5);
        check("x5_not_busy", {63'd0, rd_busy[0]}, 64'd0);

        // x0 stays zero and never busy
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = '1;
        iss_en = 1'b1; iss_addr = 5'd0;
        set_rd(5'd0, 5'd0);
        settle();
        check("x0_same_data", data0(), 64'd0);
        tick();
        wr_en = 1'b0; iss_en = 1'b0;
        settle();
        check("x0_data0", data0(), 64'd0);
        check("x0_data1", data1(), 64'd0);
        check("x0_busy", {62'd0, rd_busy}, 64'd0);

        // Scoreboard: issue x7, three idle cycles, then write x7=9
        iss_en = 1'b1; iss_addr = 5'd7;
        set_rd(5'd7, 5'd5);
        settle();
        check("x7_busy_pre", {63'd0, rd_busy[0]}, 64'd0);
        tick();
        iss_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            check($sformatf("x7_busy_idle%0d", k), {63'd0, rd_busy[0]}, 64'd1);
            tick();
        end
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'd9;
        settle();
        check("x7_busy_wb", {63'd0, rd_busy[0]}, BYP ? 64'd0 : 64'd1);
        check("x7_data_wb", data0(), BYP ? 64'd9 : 64'd0);
        tick();
        wr_en = 1'b0;
        settle();
        check("x7_busy_after", {63'd0, rd_busy[0]}, 64'd0);
        check("x7_data_after", data0(), 64'd9);

        // Same-cycle clear and set on x7: set wins
        iss_en = 1'b1; iss_addr = 5'd7;
        tick();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'd1;
        settle();
        check("conf_same_data", data0(), BYP ? 64'd1 : 64'd9);
        check("conf_same_busy", {63'd0, rd_busy[0]}, 64'd1);
        tick();
        wr_en = 1'b0; iss_en = 1'b0;
        settle();
        check("conf_data", data0(), 64'd1);
        check("conf_busy", {63'd0, rd_busy[0]}, 64'd1);
        wr_en = 1'b1; wr_data = 64'd2;
        tick();
        wr_en = 1'b0;
        settle();
        check("conf_clr_busy", {63'd0, rd_busy[0]}, 64'd0);
        check("conf_clr_data", data0(), 64'd2);

        // Reset with x4 busy, then again at sweep index 10
        iss_en = 1'b1; iss_addr = 5'd4;
        set_rd(5'd7, 5'd4);
        tick();
        iss_en = 1'b0;
        settle();
        check("x4_busy", {63'd0, rd_busy[1]}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        check("mid_ready", {63'd0, ready}, 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        wait_ready(cycles, 2, 20);
        check("restart_len", 64'(cycles), 64'd32);
        check("restart_busy", {62'd0, rd_busy}, 64'd0);
        check("restart_x7", data0(), 64'd0);
        set_rd(5'd3, 5'd4);
        settle();
        check("ignored_wr_x3", data0(), 64'd0);
        check("ignored_iss_x3", {62'd0, rd_busy}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
